// File: rtl/modulo_varredura_display_pkg.sv
// Shared segment codes (active-high {g,f,e,d,c,b,a}) and scanner state encodings.
package modulo_varredura_display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_GAP = 2'd1,
    S_ON  = 2'd2
  } state_t;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } seg_word_t;

endpackage

// File: rtl/modulo_varredura_display_decodificador.sv
// Combinational BCD to active-high 7-segment decoder; non-decimal codes show a dash.
module modulo_decodificador_7seg
  import modulo_varredura_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/modulo_varredura_display.sv
// Multiplexed 7-segment scanner: clk_div is synchronized as data and its rising
// edges pace a digit rotation with a one-cycle blank gap between digits.
module modulo_varredura_display
  import modulo_varredura_display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DWELL          = 1,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  clk_div,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an,
  output logic [2:0]            digit_idx
);

  localparam int CW = 4;
  localparam int IW = 3;
  localparam logic [6:0]          SEG_MASK = {7{ACTIVE_LOW_SEG != 0}};
  localparam logic                DP_MASK  = (ACTIVE_LOW_SEG != 0);
  localparam logic [N_DIGITS-1:0] AN_MASK  = {N_DIGITS{ACTIVE_LOW_AN != 0}};

  logic s1, s2, s3, tick, adv;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [N_DIGITS-1:0][3:0] nib;
  logic [N_DIGITS-1:0][6:0] dec;

  // One decoder per digit lane; the selected lane is muxed below.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_lane
    assign nib[g] = digits[4*g +: 4];
    modulo_decodificador_7seg u_dec (
      .bcd (nib[g]),
      .seg (dec[g])
    );
  end

  assign tick = s2 & ~s3;
  assign adv  = en & tick & (cnt == CW'(DWELL - 1));

  always_comb begin
    cnt_n = cnt;
    idx_n = idx;
    if (en && tick) begin
      if (adv) begin
        cnt_n = '0;
        idx_n = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = S_OFF;
    end else begin
      case (state)
        S_OFF:   state_n = S_GAP;
        S_GAP:   state_n = adv ? S_GAP : S_ON;
        S_ON:    state_n = adv ? S_GAP : S_ON;
        default: state_n = S_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  seg_word_t           sel, word_n;
  logic                sel_blank;
  logic [N_DIGITS-1:0] an_n;

  always_comb begin
    sel       = '{dp: 1'b0, seg: SEG_OFF};
    sel_blank = 1'b1;
    an_n      = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        sel       = '{dp: dp[i], seg: dec[i]};
        sel_blank = blank[i];
        if (state_n == S_ON && !blank[i]) an_n[i] = 1'b1;
      end
    end
    word_n = '{dp: 1'b0, seg: SEG_OFF};
    if ((state_n == S_GAP || state_n == S_ON) && !sel_blank) word_n = sel;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= S_OFF;
      idx       <= '0;
      cnt       <= '0;
      seg       <= SEG_OFF ^ SEG_MASK;
      dp_out    <= DP_MASK;
      an        <= AN_MASK;
      digit_idx <= '0;
    end else begin
      s1        <= clk_div;
      s2        <= s1;
      s3        <= s2;
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      seg       <= word_n.seg ^ SEG_MASK;
      dp_out    <= word_n.dp ^ DP_MASK;
      an        <= an_n ^ AN_MASK;
      digit_idx <= idx_n;
    end
  end

endmodule

// File: tb/tb_modulo_varredura_display.sv
// Directed bench for the display scanner: one DWELL=1 and one DWELL=3 instance
// share stimulus; expected values are hand-computed active-low codes.
module tb_modulo_varredura_display;

  logic        clk, clr, clk_div, en;
  logic [15:0] digits;
  logic [3:0]  dp, blank;

  logic [6:0] seg1, seg3;
  logic       dpo1, dpo3;
  logic [3:0] an1, an3;
  logic [2:0] di1, di3;

  int checks   = 0;
  int failures = 0;

  modulo_varredura_display #(.N_DIGITS(4), .DWELL(1), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) u1 (
    .clk(clk), .clr(clr), .clk_div(clk_div), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .seg(seg1), .dp_out(dpo1), .an(an1), .digit_idx(di1)
  );

  modulo_varredura_display #(.N_DIGITS(4), .DWELL(3), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) u3 (
    .clk(clk), .clr(clr), .clk_div(clk_div), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .seg(seg3), .dp_out(dpo3), .an(an3), .digit_idx(di3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising clk_div: after the third edge the DWELL=1 unit is in its gap cycle.
  task automatic div_rise();
    clk_div = 1'b1;
    repeat (3) step();
  endtask

  task automatic div_fall();
    clk_div = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; clk_div = 1'b0;
    digits = 16'h4321; dp = 4'b0000; blank = 4'b0000;

    // reset hold with clk_div toggling
    for (int i = 0; i < 3; i++) begin
      clk_div = ~clk_div;
      step();
    end
    chk("rst_an", an1, 4'hF);
    chk("rst_seg", seg1, 7'h7F);
    chk("rst_dp", dpo1, 1'b1);
    chk("rst_idx", di1, 3'd0);
    chk("rst_an3", an3, 4'hF);

    // release, enable: gap then digit 0
    clk_div = 1'b0; clr = 1'b1; en = 1'b1;
    step();
    chk("gap0_an", an1, 4'hF);
    chk("gap0_seg", seg1, 7'h79);
    step();
    chk("on0_an", an1, 4'hE);
    chk("on0_seg", seg1, 7'h79);

    // edge latency: rise sampled at k+1, tick after k+2, idx at k+3
    clk_div = 1'b1;
    step();
    chk("lat_k1_tick", u1.tick, 1'b0);
    chk("lat_k1_idx", di1, 3'd0);
    step();
    chk("lat_k2_tick", u1.tick, 1'b1);
    chk("lat_k2_an", an1, 4'hE);
    step();
    chk("lat_k3_tick", u1.tick, 1'b0);
    chk("lat_k3_idx", di1, 3'd1);
    chk("lat_k3_an", an1, 4'hF);
    chk("lat_k3_seg", seg1, 7'h24);
    chk("d3_hold_an", an3, 4'hE);
    div_fall();
    chk("on1_an", an1, 4'hD);
    chk("on1_seg", seg1, 7'h24);

    // pulse 2
    div_rise();
    chk("gap2_an", an1, 4'hF);
    chk("gap2_seg", seg1, 7'h30);
    div_fall();
    chk("on2_an", an1, 4'hB);

    // pulse 3: DWELL=3 unit advances on its third edge
    div_rise();
    chk("gap3_an", an1, 4'hF);
    chk("gap3_seg", seg1, 7'h19);
    chk("d3_gap1_idx", di3, 3'd1);
    chk("d3_gap1_an", an3, 4'hF);
    div_fall();
    chk("on3_an", an1, 4'h7);
    chk("d3_on1_an", an3, 4'hD);
    chk("d3_on1_seg", seg3, 7'h24);

    // pulse 4: wrap
    div_rise();
    chk("wrap_idx", di1, 3'd0);
    div_fall();
    chk("wrap_an", an1, 4'hE);
    chk("wrap_seg", seg1, 7'h79);

    // pulses 5,6 -> DWELL=1 idx 2, DWELL=3 idx 2
    div_rise(); div_fall();
    div_rise(); div_fall();
    chk("p6_an", an1, 4'hB);
    chk("d3_p6_idx", di3, 3'd2);

    // en drop mid-scan at idx 2
    en = 1'b0;
    step();
    chk("off_an", an1, 4'hF);
    chk("off_seg", seg1, 7'h7F);
    chk("off_dp", dpo1, 1'b1);
    chk("off_idx", di1, 3'd2);
    div_rise(); div_fall();
    chk("off_tick_ign", di1, 3'd2);
    chk("off_tick_ign3", di3, 3'd2);
    en = 1'b1;
    step();
    chk("resume_gap_an", an1, 4'hF);
    chk("resume_gap_idx", di1, 3'd2);
    chk("resume_gap_seg", seg1, 7'h30);
    step();
    chk("resume_on_an", an1, 4'hB);

    // blank/dash/dp pattern; live refresh shows after one clk
    digits = 16'hA000; blank = 4'b0010; dp = 4'b1000;
    step();
    chk("live_seg", seg1, 7'h40);

    // pulse 7: digit 3 dash with dp
    div_rise();
    chk("dash_gap_seg", seg1, 7'h3F);
    chk("dash_gap_dp", dpo1, 1'b0);
    div_fall();
    chk("dash_an", an1, 4'h7);
    chk("dash_seg", seg1, 7'h3F);
    chk("dash_dp", dpo1, 1'b0);

    // pulse 8: digit 0 shows '0', dp off
    div_rise(); div_fall();
    chk("z_an", an1, 4'hE);
    chk("z_seg", seg1, 7'h40);
    chk("z_dp", dpo1, 1'b1);

    // pulse 9: blanked digit 1; DWELL=3 unit reaches digit 3
    div_rise(); div_fall();
    chk("blank_an", an1, 4'hF);
    chk("blank_seg", seg1, 7'h7F);
    chk("blank_dp", dpo1, 1'b1);
    chk("blank_idx", di1, 3'd1);
    chk("d3_dash_an", an3, 4'h7);
    chk("d3_dash_idx", di3, 3'd3);
    chk("d3_dash_seg", seg3, 7'h3F);
    chk("d3_dash_dp", dpo3, 1'b0);
    div_rise(); div_fall();
    chk("after_blank_an", an1, 4'hB);

    // pulses 11,12: DWELL=3 wraps 3 -> 0
    div_rise(); div_fall();
    chk("d3_pre_wrap_idx", di3, 3'd3);
    div_rise(); div_fall();
    chk("d3_wrap_idx", di3, 3'd0);
    chk("d3_wrap_an", an3, 4'hE);
    chk("p12_idx", di1, 3'd0);

    // mid-scan reset
    div_rise(); div_fall();
    chk("pre_clr_idx", di1, 3'd1);
    clr = 1'b0;
    step();
    chk("clr_idx", di1, 3'd0);
    chk("clr_an", an1, 4'hF);
    chk("clr_seg", seg1, 7'h7F);
    chk("clr_an3", an3, 4'hF);
    clr = 1'b1;
    step();
    chk("post_clr_gap", an1, 4'hF);
    step();
    chk("post_clr_an", an1, 4'hE);
    chk("post_clr_seg", seg1, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulo_varredura_display.md
Name: modulo_varredura_display

Overview:
Multiplexed 7-segment display scanner, sitting directly downstream of the frequency divider. It consumes the divider's clk_div output as a scan-rate tick source. Internally it synchronizes clk_div into the system clock domain and edge-detects it. It then rotates through N_DIGITS BCD digits, driving one anode at a time with decoded segments and a decimal point. Single clock domain; no gated or derived clocks are used inside the block.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
DWELL, 1, clk_div rising edges spent on each digit before advancing (1..15)
ACTIVE_LOW_SEG, 1, 1 = seg/dp_out active-low (common anode), 0 = active-high
ACTIVE_LOW_AN, 1, 1 = an active-low, 0 = active-high

Ports:
clk  input  1  system clock
clr  input  1  reset, synchronous, active-low; sampled on rising clk
clk_div  input  1  divided scan clock from divider, asynchronous to block logic, treated as data
en  input  1  1 = scan, 0 = display off and index frozen
digits  input  4*N_DIGITS  BCD nibble per digit; digit i = digits[4i+3:4i]
dp  input  N_DIGITS  decimal point request per digit
blank  input  N_DIGITS  1 = digit i suppressed (anode stays inactive)
seg  output  7  segments {g,f,e,d,c,b,a}, registered
dp_out  output  1  decimal point, registered
an  output  N_DIGITS  anode enables, one-hot or none, registered
digit_idx  output  3  index of the currently selected digit, registered

Behaviour:
- Reset (clr=0 at rising clk): sync regs s1/s2/s3=0; FSM=S_OFF; idx=0; dwell count=0.
- Reset outputs: an all inactive; seg all off; dp_out off; digit_idx=0. A mid-scan reset takes effect on that same edge and has priority over everything.
- Synchronizer: s1<=clk_div, s2<=s1, s3<=s2; tick = s2 & ~s3. tick is high for exactly one clk cycle, 2 clk edges after clk_div rises. Falling edges are ignored.
- Dwell: the counter increments on tick. At a tick where count==DWELL-1: count<=0, idx<=(idx==N_DIGITS-1)?0:idx+1, and the FSM enters S_GAP.
- FSM S_OFF: outputs off. Leaves to S_GAP on the first clk with en=1.
- FSM S_GAP: exactly 1 clk with all anodes inactive (anti-ghosting). seg/dp_out are loaded with the decode of digits[idx]. Next state is S_ON.
- FSM S_ON: an[idx] active unless blank[idx]=1 (then all inactive). seg/dp_out are refreshed every clk from live inputs, so digit changes appear 1 clk later.
- en=0 in any state: next state S_OFF; outputs off on the next edge; idx and count held; ticks ignored.
- Tick arriving while in S_GAP: it is counted normally. With DWELL=1 this advances idx again, and the FSM stays in S_GAP for one more clk.
- Decode (active-high form): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. BCD 10..15 shows a dash, 40.
- Polarity: if ACTIVE_LOW_SEG, seg and dp_out are inverted. "Off" means all segments deasserted under the chosen polarity. Same rule for an with ACTIVE_LOW_AN.
- Blanked digit: seg is forced off and dp_out off, and the dwell time is still consumed, so scan timing is uniform.
- digit_idx is zero-extended to 3 bits and equals idx in S_GAP and S_ON.

Decomposition:
- Shared package: segment codes SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high); FSM state encodings S_OFF/S_GAP/S_ON (2 bits).
- One sub-module: modulo_decodificador_7seg, a combinational BCD-to-active-high-segment decoder with the dash for values above 9.
- The synchronizer and edge detector stay inline.

Test Plan:
- Reset hold: clr=0 for 3 clk with clk_div toggling -> an=4'hF, seg=7'h7F, dp_out=1, digit_idx=0 (defaults).
- Scan order: en=1, digits=16'h4321, dp=0, blank=0, clk_div period 32 clk -> an cycles E,D,B,7 with seg 79,24,30,19. Each anode change is preceded by exactly 1 clk of an=F.
- Edge latency: clk_div rises at edge k -> tick is high in the cycle after edge k+2 (pulse width 1 clk). idx updates at edge k+3.
- Blank/dash/dp: digits=16'hA000, blank=4'b0010, dp=4'b1000 -> digit1 keeps an=F for its dwell; digit3 shows seg=3F (dash) with dp_out=0.
- DWELL=3: each digit persists for 3 clk_div rising edges. Wrap from idx=3 to 0 is verified.
- en drop mid-scan at idx=2 -> outputs off on the next edge. en reasserted -> resumes at idx=2 via S_GAP. Mid-scan clr=0 -> idx=0 on that edge.
